// File: rtl/gb_csr_bank.sv
// gb_csr_bank: parametrised ghostbus local decoder.
// It provides NREG CSRs with write strobes and optional read-only hardware
// mapping, one RAM region with a user read port, address-window fan-out to
// NCHILD child buses, and registered read-data return.
// Optional macro GB_CSR_BANK_RDPIPE_EN adds one more register stage on the
// read return, which makes the local and child read latency 2 cycles.
module gb_csr_bank #(
  parameter int              AW       = 12,
  parameter int              DW       = 32,
  parameter int              NREG     = 8,
  parameter int              RW       = 8,
  parameter logic [NREG-1:0] RO_MASK  = '0,
  parameter int              RAM_AW   = 3,
  parameter int              RAM_DW   = 4,
  parameter int              RAM_BASE = 'h40,
  parameter int              CWIN     = 9,
  parameter int              NCHILD   = 2
) (
  input  logic                                        gb_clk,
  input  logic                                        gb_rst,
  input  logic [AW-1:0]                               gb_addr,
  input  logic [DW-1:0]                               gb_dout,
  input  logic                                        gb_we,
  output logic [DW-1:0]                               gb_din,
  output logic [NREG*RW-1:0]                          reg_q,
  output logic [NREG-1:0]                             reg_stb,
  input  logic [NREG*RW-1:0]                          reg_hw,
  input  logic [RAM_AW-1:0]                           ram_raddr,
  output logic [RAM_DW-1:0]                           ram_rdata,
  // With NCHILD=0 the child ports keep one tied-off slot, because a
  // zero-width port is not legal.
  output logic [((NCHILD > 0) ? NCHILD : 1)*AW-1:0]   child_addr,
  output logic [((NCHILD > 0) ? NCHILD : 1)-1:0]      child_we,
  input  logic [((NCHILD > 0) ? NCHILD : 1)*DW-1:0]   child_din
);

  localparam int RAM_N = 2 ** RAM_AW;
  localparam int SW    = $clog2(NCHILD + 2);

  // Encoding of the region select: 0 = none, 1 = local, k+2 = child k.
  localparam logic [SW-1:0] SEL_NONE  = SW'(0);
  localparam logic [SW-1:0] SEL_LOCAL = SW'(1);

  // A RAM region that is misaligned or overlaps the CSRs cannot be decoded.
  if ((RAM_BASE % RAM_N) != 0 || RAM_BASE < NREG ||
      RAM_BASE + RAM_N > 2 ** CWIN) begin : g_bad_ram_base
    $error("gb_csr_bank: RAM_BASE must be 2**RAM_AW aligned, >= NREG and inside the local window");
  end

  logic [AW-CWIN-1:0] win;
  logic [CWIN-1:0]    off;
  logic [31:0]        win32;
  logic [31:0]        off32;
  logic               is_local;
  logic               is_ram;
  logic               wr_local;
  logic [RAM_AW-1:0]  ram_widx;
  logic [SW-1:0]      sel_d;
  logic [SW-1:0]      sel_q;
  logic [DW-1:0]      rd_val;
  logic [DW-1:0]      local_q;
  logic [DW-1:0]      ret;
  logic [RAM_DW-1:0]  ram [RAM_N];

  // Host data bits above RW/RAM_DW are discarded, and reg_hw slices of
  // writable CSRs are never read.
  logic unused_bits;
  assign unused_bits = ^{gb_dout, reg_hw};

  assign win      = gb_addr[AW-1:CWIN];
  assign off      = gb_addr[CWIN-1:0];
  assign win32    = 32'(win);
  assign off32    = 32'(off);
  assign is_local = (win32 == 32'd0);
  assign is_ram   = (off32 >= 32'(RAM_BASE)) && (off32 < 32'(RAM_BASE + RAM_N));
  assign wr_local = gb_we && is_local;
  assign ram_widx = off[RAM_AW-1:0];

  // Each child sees the window offset and a write enable for its own window.
  if (NCHILD > 0) begin : g_child
    for (genvar k = 0; k < NCHILD; k++) begin : g_k
      assign child_addr[k*AW +: AW] = AW'(off);
      assign child_we[k]            = gb_we && (win32 == 32'(k + 1));
    end
  end else begin : g_nochild
    assign child_addr = '0;
    assign child_we   = '0;
  end

  // Which region answers the current address: local, one child, or none.
  always_comb begin
    sel_d = SEL_NONE;
    if (is_local) begin
      sel_d = SEL_LOCAL;
    end else if (win32 >= 32'd1 && win32 <= 32'(NCHILD)) begin
      sel_d = SW'(win32 + 32'd1);
    end
  end

  // Local read data: CSR value, hardware value for read-only CSRs, or RAM.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if (off32 == 32'(i)) begin
        rd_val = RO_MASK[i] ? DW'(reg_hw[i*RW +: RW]) : DW'(reg_q[i*RW +: RW]);
      end
    end
    if (is_ram) begin
      rd_val = DW'(ram[ram_widx]);
    end
  end

  // CSR storage and one-cycle strobes; writes to read-only CSRs are dropped.
  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) begin
      reg_q   <= '0;
      reg_stb <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        reg_stb[i] <= wr_local && (off32 == 32'(i)) && !RO_MASK[i];
        if (wr_local && (off32 == 32'(i)) && !RO_MASK[i]) begin
          reg_q[i*RW +: RW] <= gb_dout[RW-1:0];
        end
      end
    end
  end

  // RAM contents survive reset; writes are blocked while reset is high.
  always_ff @(posedge gb_clk) begin
    if (wr_local && is_ram && !gb_rst) begin
      ram[ram_widx] <= gb_dout[RAM_DW-1:0];
    end
  end

  // Registered user RAM port, local read data and region select.
  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) begin
      ram_rdata <= '0;
      local_q   <= '0;
      sel_q     <= SEL_NONE;
    end else begin
      ram_rdata <= ram[ram_raddr];
      local_q   <= (is_local && !gb_we) ? rd_val : '0;
      sel_q     <= sel_d;
    end
  end

  // Return mux steered by the region selected one cycle earlier.
  always_comb begin
    ret = '0;
    if (sel_q == SEL_LOCAL) begin
      ret = local_q;
    end
    for (int k = 0; k < NCHILD; k++) begin
      if (sel_q == SW'(k + 2)) begin
        ret = child_din[k*DW +: DW];
      end
    end
  end

`ifdef GB_CSR_BANK_RDPIPE_EN
  logic [DW-1:0] din_q;

  // Extra return stage for timing closure on wide decoders.
  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) begin
      din_q <= '0;
    end else begin
      din_q <= ret;
    end
  end

  assign gb_din = din_q;
`else
  assign gb_din = ret;
`endif

endmodule

// File: tb/tb_gb_csr_bank.sv
// tb_gb_csr_bank: randomized and directed self-checking bench for gb_csr_bank
// with RO_MASK = 8'h20, using a behavioural model of CSRs, RAM and children.
module tb_gb_csr_bank;

  localparam logic [7:0] RO = 8'h20;
`ifdef GB_CSR_BANK_RDPIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        gb_clk;
  logic        gb_rst;
  logic [11:0] gb_addr;
  logic [31:0] gb_dout;
  logic        gb_we;
  logic [31:0] gb_din;
  logic [63:0] reg_q;
  logic [7:0]  reg_stb;
  logic [63:0] reg_hw;
  logic [2:0]  ram_raddr;
  logic [3:0]  ram_rdata;
  logic [23:0] child_addr;
  logic [1:0]  child_we;
  logic [63:0] child_din;

  typedef struct {
    bit          chk;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  csr_m [8];
  logic [3:0]  ram_m [8];
  bit          ram_ok [8];
  logic [31:0] child_mem [2][16];
  int          errors = 0;
  int          checks = 0;

  gb_csr_bank #(.RO_MASK(RO)) dut (
    .gb_clk(gb_clk), .gb_rst(gb_rst), .gb_addr(gb_addr), .gb_dout(gb_dout),
    .gb_we(gb_we), .gb_din(gb_din), .reg_q(reg_q), .reg_stb(reg_stb),
    .reg_hw(reg_hw), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .child_addr(child_addr), .child_we(child_we), .child_din(child_din)
  );

  initial gb_clk = 1'b0;
  always #5 gb_clk = ~gb_clk;

  // Child buses: each answers one cycle after the address from a small table.
  always @(posedge gb_clk) begin
    for (int k = 0; k < 2; k++) begin
      child_din[k*32 +: 32] <= child_mem[k][child_addr[k*12 +: 4]];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected host read data from the address map, computed before the edge.
  function automatic exp_t model_read(input logic [11:0] a);
    exp_t e;
    int   w;
    int   o;
    w = int'(a[11:9]);
    o = int'(a[8:0]);
    e.chk = 1'b1;
    e.val = 32'd0;
    if (w == 0) begin
      if (o < 8) begin
        e.val = RO[o] ? {24'd0, reg_hw[o*8 +: 8]} : {24'd0, csr_m[o]};
      end else if (o >= 'h40 && o < 'h48) begin
        e.val = {28'd0, ram_m[o - 'h40]};
        e.chk = ram_ok[o - 'h40];
      end
    end else if (w <= 2) begin
      e.val = child_mem[w-1][o % 16];
    end
    return e;
  endfunction

  function automatic logic [63:0] packed_csr();
    logic [63:0] p;
    for (int i = 0; i < 8; i++) p[i*8 +: 8] = csr_m[i];
    return p;
  endfunction

  // One bus cycle: drive inputs, check fan-out, advance the model, check results.
  task automatic applyStimulus(input logic [11:0] a, input logic [31:0] d,
                               input logic we, input logic [2:0] raddr);
    exp_t        e;
    logic [1:0]  exp_cwe;
    logic [7:0]  exp_stb;
    logic [3:0]  exp_ram;
    bit          ram_chk;
    int          o;
    gb_addr   = a;
    gb_dout   = d;
    gb_we     = we;
    ram_raddr = raddr;
    #1;
    for (int k = 0; k < 2; k++) exp_cwe[k] = we && (a[11:9] == 3'(k + 1));
    checkOutput("child_we", 64'(child_we), 64'(exp_cwe));
    checkOutput("child_addr", 64'(child_addr), 64'({3'd0, a[8:0], 3'd0, a[8:0]}));
    e = model_read(a);
    if (we) e.chk = 1'b0;
    exp_q.push_back(e);
    exp_ram = ram_m[raddr];
    ram_chk = ram_ok[raddr];
    exp_stb = 8'd0;
    o = int'(a[8:0]);
    if (we && a[11:9] == 3'd0) begin
      if (o < 8 && !RO[o]) begin
        csr_m[o]   = d[7:0];
        exp_stb[o] = 1'b1;
      end
      if (o >= 'h40 && o < 'h48) begin
        ram_m[o - 'h40]  = d[3:0];
        ram_ok[o - 'h40] = 1'b1;
      end
    end
    @(posedge gb_clk);
    #1;
    checkOutput("reg_stb", 64'(reg_stb), 64'(exp_stb));
    checkOutput("reg_q", reg_q, packed_csr());
    if (ram_chk) checkOutput("ram_rdata", 64'(ram_rdata), 64'(exp_ram));
    if (exp_q.size() == LAT) begin
      e = exp_q.pop_front();
      if (e.chk) checkOutput("gb_din", 64'(gb_din), 64'(e.val));
    end
  endtask

  initial begin
    logic [11:0] a;
    gb_rst    = 1'b1;
    gb_addr   = '0;
    gb_dout   = '0;
    gb_we     = 1'b0;
    ram_raddr = '0;
    reg_hw    = {$urandom, $urandom};
    reg_hw[5*8 +: 8] = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      csr_m[i]  = 8'd0;
      ram_m[i]  = 4'd0;
      ram_ok[i] = 1'b0;
    end
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 16; j++) child_mem[k][j] = $urandom;

    repeat (2) @(posedge gb_clk);
    #1;
    checkOutput("rst_gb_din", 64'(gb_din), 64'd0);
    checkOutput("rst_reg_q", reg_q, 64'd0);
    checkOutput("rst_reg_stb", 64'(reg_stb), 64'd0);
    checkOutput("rst_ram_rdata", 64'(ram_rdata), 64'd0);
    gb_rst = 1'b0;
    $display("[TB] reset released, LAT=%0d", LAT);

    for (int i = 0; i < 8; i++) applyStimulus(12'(i), 32'd0, 1'b0, 3'd0);
    applyStimulus(12'h000, 32'h1A5, 1'b1, 3'd0);
    applyStimulus(12'h000, 32'd0, 1'b0, 3'd0);
    applyStimulus(12'h002, 32'h11, 1'b1, 3'd0);
    applyStimulus(12'h003, 32'h22, 1'b1, 3'd0);
    applyStimulus(12'h002, 32'h33, 1'b1, 3'd0);
    applyStimulus(12'h005, 32'h99, 1'b1, 3'd0);
    applyStimulus(12'h005, 32'd0, 1'b0, 3'd0);
    applyStimulus(12'h002, 32'd0, 1'b0, 3'd0);

    for (int i = 0; i < 8; i++) applyStimulus(12'h040 + 12'(i), 32'(i), 1'b1, 3'd0);
    applyStimulus(12'h000, 32'd0, 1'b0, 3'd3);
    applyStimulus(12'h043, 32'hF, 1'b1, 3'd3);
    applyStimulus(12'h043, 32'd0, 1'b0, 3'd3);

    applyStimulus(12'h200, 32'h1234, 1'b1, 3'd0);
    child_mem[1][15] = 32'hDEADBEEF;
    applyStimulus(12'h7FF, 32'd0, 1'b0, 3'd0);
    applyStimulus(12'hA00, 32'd0, 1'b0, 3'd0);
    applyStimulus(12'hE00, 32'd0, 1'b0, 3'd0);
    applyStimulus(12'h047, 32'd0, 1'b0, 3'd7);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 4))
        0:       a = 12'($urandom_range(0, 9));
        1:       a = 12'($urandom_range('h3E, 'h49));
        2:       a = {3'd1, 9'($urandom)};
        3:       a = {3'd2, 9'($urandom)};
        default: a = {3'($urandom_range(3, 7)), 9'($urandom)};
      endcase
      reg_hw = {$urandom, $urandom};
      applyStimulus(a, $urandom, 1'($urandom_range(0, 1)), 3'($urandom));
    end

    applyStimulus(12'h001, 32'd0, 1'b0, 3'd0);
    gb_rst = 1'b1;
    #1;
    checkOutput("midrst_gb_din", 64'(gb_din), 64'd0);
    checkOutput("midrst_reg_q", reg_q, 64'd0);
    checkOutput("midrst_ram_rdata", 64'(ram_rdata), 64'd0);
    for (int i = 0; i < 8; i++) csr_m[i] = 8'd0;
    exp_q.delete();
    gb_addr = 12'h001;
    gb_dout = 32'h77;
    gb_we   = 1'b1;
    @(posedge gb_clk);
    #1;
    gb_addr = 12'h045;
    gb_dout = 32'h9;
    @(posedge gb_clk);
    #1;
    checkOutput("rst_write_reg_q", reg_q, 64'd0);
    checkOutput("rst_write_stb", 64'(reg_stb), 64'd0);
    gb_we  = 1'b0;
    gb_rst = 1'b0;

    applyStimulus(12'h001, 32'd0, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) applyStimulus(12'h040 + 12'(i), 32'd0, 1'b0, 3'(i));
    applyStimulus(12'h7F0, 32'd0, 1'b0, 3'd5);
    applyStimulus(12'hE00, 32'd0, 1'b0, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
